// File: rtl/data_mem_resp_if.sv
// Request/response bus for data_mem_resp.
// master: the requester (drives strobes, address, store data, size/extension).
// slave : the memory responder (drives rdata, ready, busy, err).
interface data_mem_resp_if;
   logic        rmem;
   logic        wmem;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [1:0]  mem_type;
   logic        mem_sign;
   logic [31:0] rdata;
   logic        ready;
   logic        busy;
   logic        err;

   modport master (
      output rmem, wmem, addr, wdata, mem_type, mem_sign,
      input  rdata, ready, busy, err
   );

   modport slave (
      input  rmem, wmem, addr, wdata, mem_type, mem_sign,
      output rdata, ready, busy, err
   );
endinterface

// File: rtl/data_mem_resp.sv
// data_mem_resp: single-request data memory with a fixed-latency response.
// A request accepted in IDLE optionally waits WAIT_CYC cycles, spends two
// cycles in ACCESS (RAM read, then lane write / load formatting) and then
// pulses ready for one cycle in RESP.
// Optional feature: define MEM_RESP_MISALIGN_EN to flag misaligned half/word
// accesses as errors instead of silently aligning them.
module data_mem_resp #(
   parameter int DEPTH_LOG2 = 10,
   parameter int WAIT_CYC   = 0
) (
   input  logic            clk,
   input  logic            rst,
   data_mem_resp_if.slave  bus
);

   localparam logic [2:0] WAIT_LAST = (WAIT_CYC > 0) ? 3'(WAIT_CYC - 1) : 3'd0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        ph_q, ph_d;

   logic [DEPTH_LOG2+1:0] addr_q;
   logic [31:0] wdata_q;
   logic [1:0]  type_q;
   logic        sign_q;
   logic        wr_q;
   logic        bad_q;
   logic [31:0] rd_word_q;
   logic [31:0] rdata_q;

   logic [31:0] mem [0:(2**DEPTH_LOG2)-1];

   logic        accept;
   logic        misalign;
   logic        bad_req;
   logic [DEPTH_LOG2-1:0] idx;
   logic [3:0]  lane;
   logic [31:0] wr_word;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_val;
   logic        ram_rd;
   logic        ram_we;
   logic        addr_unused;

   // High address bits are intentionally dropped so addresses wrap.
   assign addr_unused = ^bus.addr[31:DEPTH_LOG2+2];

   // Request acceptance and up-front error classification
   always_comb begin
      accept = (state_q == ST_IDLE) && (bus.rmem || bus.wmem);
`ifdef MEM_RESP_MISALIGN_EN
      misalign = ((bus.mem_type == 2'b01) && bus.addr[0]) ||
                 ((bus.mem_type == 2'b10) && (bus.addr[1:0] != 2'b00));
`else
      misalign = 1'b0;
`endif
      bad_req = (bus.rmem && bus.wmem) || (bus.mem_type == 2'b11) || misalign;
   end

   // State register, wait counter and access phase
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ph_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ph_q    <= ph_d;
      end
   end

   // Next-state logic; ACCESS is two cycles: RAM read, then write/format
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ph_d    = ph_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               cnt_d   = '0;
               ph_d    = 1'b0;
               state_d = (WAIT_CYC > 0) ? ST_WAIT : ST_ACCESS;
            end
         end
         ST_WAIT: begin
            if (cnt_q == WAIT_LAST) begin
               cnt_d   = '0;
               state_d = ST_ACCESS;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         ST_ACCESS: begin
            if (ph_q) begin
               ph_d    = 1'b0;
               state_d = ST_RESP;
            end else begin
               ph_d = 1'b1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Bus outputs decoded from state
   always_comb begin
      bus.ready = (state_q == ST_RESP);
      bus.err   = (state_q == ST_RESP) && bad_q;
      bus.busy  = (state_q != ST_IDLE);
      bus.rdata = rdata_q;
   end

   // Request capture and load result register
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         type_q  <= '0;
         sign_q  <= 1'b0;
         wr_q    <= 1'b0;
         bad_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            addr_q  <= bus.addr[DEPTH_LOG2+1:0];
            wdata_q <= bus.wdata;
            type_q  <= bus.mem_type;
            sign_q  <= bus.mem_sign;
            wr_q    <= bus.wmem;
            bad_q   <= bad_req;
         end
         if ((state_q == ST_ACCESS) && ph_q && !wr_q && !bad_q) begin
            rdata_q <= load_val;
         end
      end
   end

   // Byte-lane enables and replicated store data
   always_comb begin
      idx     = addr_q[DEPTH_LOG2+1:2];
      lane    = 4'b0000;
      wr_word = wdata_q;
      case (type_q)
         2'b00: begin
            lane    = 4'b0001 << addr_q[1:0];
            wr_word = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            lane    = addr_q[1] ? 4'b1100 : 4'b0011;
            wr_word = {2{wdata_q[15:0]}};
         end
         2'b10: begin
            lane    = 4'b1111;
            wr_word = wdata_q;
         end
         default: begin
            lane    = 4'b0000;
            wr_word = wdata_q;
         end
      endcase
   end

   // Load selection and extension from the registered RAM word
   always_comb begin
      case (addr_q[1:0])
         2'b00:   byte_sel = rd_word_q[7:0];
         2'b01:   byte_sel = rd_word_q[15:8];
         2'b10:   byte_sel = rd_word_q[23:16];
         default: byte_sel = rd_word_q[31:24];
      endcase
      half_sel = addr_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
      case (type_q)
         2'b00:   load_val = sign_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         2'b01:   load_val = sign_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: load_val = rd_word_q;
      endcase
   end

   // RAM enables; rst gates the write so a reset during ACCESS leaves memory intact
   always_comb begin
      ram_rd = (state_q == ST_ACCESS) && !ph_q && !bad_q;
      ram_we = (state_q == ST_ACCESS) && ph_q && wr_q && !bad_q && !rst;
   end

   // RAM array: synchronous read, per-lane write, no reset
   always_ff @(posedge clk) begin
      if (ram_rd) begin
         rd_word_q <= mem[idx];
      end
      if (ram_we) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (lane[b]) begin
               mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: one instance with WAIT_CYC=0 and one
// with WAIT_CYC=3, expected values computed by hand.
module tb_data_mem_resp;

   logic clk = 1'b0;
   logic rst0, rst1;
   int   n_chk = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   data_mem_resp_if bus0 ();
   data_mem_resp_if bus1 ();

   data_mem_resp #(.DEPTH_LOG2(10), .WAIT_CYC(0)) dut0 (
      .clk (clk),
      .rst (rst0),
      .bus (bus0)
   );

   data_mem_resp #(.DEPTH_LOG2(10), .WAIT_CYC(3)) dut1 (
      .clk (clk),
      .rst (rst1),
      .bus (bus1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drive(input int d, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] t, input logic s);
      if (d == 0) begin
         bus0.rmem = r; bus0.wmem = w; bus0.addr = a;
         bus0.wdata = wd; bus0.mem_type = t; bus0.mem_sign = s;
      end else begin
         bus1.rmem = r; bus1.wmem = w; bus1.addr = a;
         bus1.wdata = wd; bus1.mem_type = t; bus1.mem_sign = s;
      end
   endtask

   function automatic logic [2:0] rsp(input int d);
      if (d == 0) return {bus0.ready, bus0.err, bus0.busy};
      else        return {bus1.ready, bus1.err, bus1.busy};
   endfunction

   function automatic logic [31:0] rdv(input int d);
      if (d == 0) return bus0.rdata;
      else        return bus1.rdata;
   endfunction

   // One request: lat = edges after the sampling edge until ready is seen (-1 on timeout)
   task automatic op(input string tag, input int d, input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] wd, input logic [1:0] t,
                     input logic s, input int exp_lat, input logic exp_err,
                     input logic [31:0] exp_rd);
      int          lat;
      logic        e;
      logic [31:0] rd;
      logic [2:0]  st;
      @(negedge clk);
      drive(d, r, w, a, wd, t, s);
      @(posedge clk); #1;
      drive(d, 1'b0, 1'b0, a, wd, t, s);
      st = rsp(d);
      chk({tag, "/busy"}, {31'h0, st[0]}, 32'h1);
      lat = -1; e = 1'b0; rd = '0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #1;
         st = rsp(d);
         if (st[2]) begin
            lat = i; e = st[1]; rd = rdv(d);
            break;
         end
      end
      chk({tag, "/lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "/err"}, {31'h0, e}, {31'h0, exp_err});
      chk({tag, "/rdata"}, rd, exp_rd);
      if (lat > 0) begin
         @(posedge clk); #1;
         chk({tag, "/pulse"}, {29'h0, rsp(d)}, 32'h0);
      end
   endtask

   initial begin
      logic quiet;
      drive(0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
      drive(1, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
      rst0 = 1'b1;
      rst1 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst0/flags", {29'h0, rsp(0)}, 32'h0);
      chk("rst0/rdata", rdv(0), 32'h0);
      chk("rst1/flags", {29'h0, rsp(1)}, 32'h0);
      @(negedge clk);
      rst0 = 1'b0;
      rst1 = 1'b0;

      // WAIT_CYC=0 instance
      op("sw10",   0, 0, 1, 32'h10,   32'hDEADBEEF, 2'b10, 0, 2, 0, 32'h0);
      op("lw10",   0, 1, 0, 32'h10,   32'h0,        2'b10, 0, 2, 0, 32'hDEADBEEF);
      op("lb13",   0, 1, 0, 32'h13,   32'h0,        2'b00, 0, 2, 0, 32'hFFFFFFDE);
      op("lhu10",  0, 1, 0, 32'h10,   32'h0,        2'b01, 1, 2, 0, 32'h0000BEEF);
      op("lbu10",  0, 1, 0, 32'h10,   32'h0,        2'b00, 1, 2, 0, 32'h000000EF);
      op("lh12",   0, 1, 0, 32'h12,   32'h0,        2'b01, 0, 2, 0, 32'hFFFFDEAD);
      op("sb11",   0, 0, 1, 32'h11,   32'h1234565A, 2'b00, 0, 2, 0, 32'hFFFFDEAD);
      op("lw_sb",  0, 1, 0, 32'h10,   32'h0,        2'b10, 0, 2, 0, 32'hDEAD5AEF);
      op("sh12",   0, 0, 1, 32'h12,   32'hFFFF8001, 2'b01, 0, 2, 0, 32'hDEAD5AEF);
      op("lwwrap", 0, 1, 0, 32'h1010, 32'h0,        2'b10, 0, 2, 0, 32'h80015AEF);
      op("both",   0, 1, 1, 32'h10,   32'h0,        2'b10, 0, 2, 1, 32'h80015AEF);
      op("swrsv",  0, 0, 1, 32'h10,   32'h0,        2'b11, 0, 2, 1, 32'h80015AEF);
      op("lwrsv",  0, 1, 0, 32'h10,   32'h0,        2'b11, 0, 2, 1, 32'h80015AEF);
      op("lw_unch",0, 1, 0, 32'h10,   32'h0,        2'b10, 0, 2, 0, 32'h80015AEF);
`ifdef MEM_RESP_MISALIGN_EN
      op("lhu11",  0, 1, 0, 32'h11,   32'h0,        2'b01, 1, 2, 1, 32'h80015AEF);
      op("lw12",   0, 1, 0, 32'h12,   32'h0,        2'b10, 0, 2, 1, 32'h80015AEF);
`else
      op("lhu11",  0, 1, 0, 32'h11,   32'h0,        2'b01, 1, 2, 0, 32'h00005AEF);
      op("lw12",   0, 1, 0, 32'h12,   32'h0,        2'b10, 0, 2, 0, 32'h80015AEF);
`endif

      // Strobes while busy are ignored: a write held through the busy window must not land
      op("sw40",   0, 0, 1, 32'h40,   32'hAAAAAAAA, 2'b10, 0, 2, 0, 32'h80015AEF);
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b1, 32'h40, 32'h0, 2'b10, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("ign/resp", {29'h0, rsp(0)}, 32'h5);
      chk("ign/rdata", rdv(0), 32'hAAAAAAAA);
      @(posedge clk); #1;
      chk("ign/idle", {29'h0, rsp(0)}, 32'h0);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
      op("lbu40",  0, 1, 0, 32'h40,   32'h0,        2'b00, 1, 2, 0, 32'h000000AA);

      // Reset in the second ACCESS cycle suppresses the write and the response
      @(negedge clk);
      drive(0, 1'b0, 1'b1, 32'h40, 32'h12345678, 2'b10, 1'b0);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
      @(posedge clk); #1;
      rst0 = 1'b1;
      @(posedge clk); #1;
      chk("rstacc/flags", {29'h0, rsp(0)}, 32'h0);
      chk("rstacc/rdata", rdv(0), 32'h0);
      rst0 = 1'b0;
      quiet = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (rsp(0) != 3'b000) quiet = 1'b0;
      end
      chk("rstacc/quiet", {31'h0, quiet}, 32'h1);
      op("lw40",   0, 1, 0, 32'h40,   32'h0,        2'b10, 0, 2, 0, 32'hAAAAAAAA);

      // WAIT_CYC=3 instance
      op("d1sw",   1, 0, 1, 32'h20,   32'hCAFEF00D, 2'b10, 0, 5, 0, 32'h0);
      op("d1lw",   1, 1, 0, 32'h20,   32'h0,        2'b10, 0, 5, 0, 32'hCAFEF00D);
      @(negedge clk);
      drive(1, 1'b1, 1'b0, 32'h20, 32'h0, 2'b00, 1'b1);
      @(posedge clk); #1;
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
      @(posedge clk); #1;
      rst1 = 1'b1;
      @(posedge clk); #1;
      chk("d1rst/flags", {29'h0, rsp(1)}, 32'h0);
      rst1 = 1'b0;
      quiet = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (rsp(1) != 3'b000) quiet = 1'b0;
      end
      chk("d1rst/quiet", {31'h0, quiet}, 32'h1);
      op("d1lbu",  1, 1, 0, 32'h20,   32'h0,        2'b00, 1, 5, 0, 32'h0000000D);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
